// File: rtl/std_mem_pkg.sv
// Shared definitions for the standard memory wrappers: controller states,
// technology selection and a constant clog2 helper.
package std_mem_pkg;

  typedef enum logic [1:0] {
    RST_ST = 2'd0,
    INIT   = 2'd1,
    RUN    = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    TECH_TSMC   = 2'd0,
    TECH_SMIC12 = 2'd1,
    TECH_FPGA   = 2'd2
  } mem_tech_e;

`ifdef FPGA
  localparam mem_tech_e MEM_TECH = TECH_FPGA;
`elsif SMIC12
  localparam mem_tech_e MEM_TECH = TECH_SMIC12;
`else
  localparam mem_tech_e MEM_TECH = TECH_TSMC;
`endif

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/std_spram_tile.sv
// One TILE_DEPTH x DATA_WIDTH single-port tile with bit-level active-low write
// enable; clk_en stands in for the macro's ICG, which opens only when CEB is low.
module std_spram_tile
  import std_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TILE_DEPTH = 32,
  localparam int TA = clog2(TILE_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [DATA_WIDTH-1:0] BWEB,
  input  logic [TA-1:0]         A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);

  logic [DATA_WIDTH-1:0] mem [TILE_DEPTH];
  logic                  clk_en;

  assign clk_en = ~CEB;

  // A write leaves Q untouched, matching the hard macros' read-only output latch.
  always_ff @(posedge CLK) begin
    if (clk_en) begin
      if (!WEB) begin
        for (int b = 0; b < DATA_WIDTH; b++) begin
          if (!BWEB[b]) mem[A][b] <= D[b];
        end
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/std_spram_tiled.sv
// Parametrised single-port SRAM built from NUM_TILES identical tiles, with
// byte write mask, optional output register and post-reset zero sweep.
module std_spram_tiled
  import std_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int TILE_DEPTH = 32,
  parameter int NUM_TILES  = 4,
  parameter int OUT_REG    = 0,
  parameter int INIT_ZERO  = 1,
  localparam int NB = DATA_WIDTH / BYTE_WIDTH,
  localparam int TA = clog2(TILE_DEPTH),
  localparam int TS = (NUM_TILES > 1) ? clog2(NUM_TILES) : 1,
  localparam int AW = TA + TS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEB,
  input  logic                  WEB,
  input  logic [NB-1:0]         BWEB,
  input  logic [AW-1:0]         A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QVALID,
  output logic                  READY
);

  mem_state_e            state_q, state_d;
  logic [TA-1:0]         init_cnt;
  logic [TS-1:0]         tile_sel;
  logic                  in_range;
  logic                  acc;
  logic [DATA_WIDTH-1:0] bweb_bits;

  logic [NUM_TILES-1:0]  t_ceb;
  logic                  t_web;
  logic [DATA_WIDTH-1:0] t_bweb;
  logic [TA-1:0]         t_a;
  logic [DATA_WIDTH-1:0] t_d;
  logic [DATA_WIDTH-1:0] tile_q [NUM_TILES];

  logic                  vld_p0;
  logic [TS-1:0]         sel_p0;
  logic                  oor_p0;
  logic [DATA_WIDTH-1:0] rd_data_p0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RST_ST;
      init_cnt <= '0;
    end else begin
      state_q  <= state_d;
      init_cnt <= (state_q == INIT) ? init_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_ST:  state_d = (INIT_ZERO != 0) ? INIT : RUN;
      INIT:    if (init_cnt == TA'(TILE_DEPTH - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = RST_ST;
    endcase
  end

  assign READY    = (state_q == RUN);
  assign tile_sel = A[AW-1:TA];
  // Extra leading bit so the compare still works when NUM_TILES is 2**TS.
  assign in_range = ({1'b0, tile_sel} < (TS + 1)'(NUM_TILES));
  assign acc      = READY & ~CEB;

  always_comb begin
    bweb_bits = '0;
    for (int i = 0; i < NB; i++) begin
      bweb_bits[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{BWEB[i]}};
    end
  end

  // The init sweep takes over every tile at once; otherwise only the decoded tile is enabled.
  always_comb begin
    t_ceb  = '1;
    t_web  = WEB;
    t_bweb = bweb_bits;
    t_a    = A[TA-1:0];
    t_d    = D;
    if (state_q == INIT) begin
      t_ceb  = '0;
      t_web  = 1'b0;
      t_bweb = '0;
      t_a    = init_cnt;
      t_d    = '0;
    end else if (acc && in_range) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        if (tile_sel == TS'(t)) t_ceb[t] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_tile
    std_spram_tile #(
      .DATA_WIDTH (DATA_WIDTH),
      .TILE_DEPTH (TILE_DEPTH)
    ) u_tile (
      .CLK  (CLK),
      .CEB  (t_ceb[g]),
      .WEB  (t_web),
      .BWEB (t_bweb),
      .A    (t_a),
      .D    (t_d),
      .Q    (tile_q[g])
    );
  end

  // Stage p0: tile select travels with the macro read so the mux lines up with its data.
  always_ff @(posedge CLK) begin
    if (RST) vld_p0 <= 1'b0;
    else     vld_p0 <= acc & WEB;
  end

  always_ff @(posedge CLK) begin
    if (acc && WEB) begin
      sel_p0 <= tile_sel;
      oor_p0 <= ~in_range;
    end
  end

  always_comb begin
    rd_data_p0 = '0;
    if (!oor_p0) begin
      for (int t = 0; t < NUM_TILES; t++) begin
        if (sel_p0 == TS'(t)) rd_data_p0 = tile_q[t];
      end
    end
  end

  // Stage p1: optional output register, holding Q between reads.
  if (OUT_REG != 0) begin : g_out_reg
    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] q_p1;

    always_ff @(posedge CLK) begin
      if (RST) begin
        vld_p1 <= 1'b0;
        q_p1   <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) q_p1 <= rd_data_p0;
      end
    end

    assign Q      = q_p1;
    assign QVALID = vld_p1;
  end else begin : g_out_comb
    assign Q      = rd_data_p0;
    assign QVALID = vld_p0;
  end

endmodule

// File: doc/std_spram_tiled.md
# std_spram_tiled

Parametrised single-port SRAM built from a row of identical macro tiles. It generalises the fixed 32x32 single-port wrapper in four ways:
- configurable width and depth;
- per-byte write mask;
- optional output register stage;
- hardware zero-initialisation sequencer after reset.

It sits between compute/buffer controllers and the technology macros, and is the standard storage primitive for new scratchpads.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-mask lane.
- TILE_DEPTH, 32, words per macro tile; power of two.
- NUM_TILES, 4, tile count; total depth DEPTH = NUM_TILES*TILE_DEPTH.
- OUT_REG, 0, 1 adds a registered output stage (+1 cycle read latency).
- INIT_ZERO, 1, 1 clears the whole array after reset.
- Derived, not overridable:
  - NB = DATA_WIDTH/BYTE_WIDTH;
  - TA = clog2(TILE_DEPTH);
  - TS = clog2(NUM_TILES), minimum 1;
  - AW = TA+TS.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- CEB  in  1  chip enable, active low; one access per cycle when low.
- WEB  in  1  0 = write, 1 = read (qualified by CEB=0).
- BWEB  in  NB  byte write enable, active low; bit i=0 writes byte i.
- A  in  AW  word address; bits [TA-1:0] select the word, [AW-1:TA] select the tile.
- D  in  DATA_WIDTH  write data.
- Q  out  DATA_WIDTH  read data.
- QVALID  out  1  one-cycle pulse marking Q valid for a read.
- READY  out  1  1 = accesses accepted; 0 during reset/initialisation.

## Operation
State machine, states RST_ST, INIT, RUN:
- RST=1:
  - Forces RST_ST and clears the init counter.
  - Clears READY, QVALID and the pipeline valid bits.
  - Clears Q when OUT_REG=1.
  - Reset mid-INIT restarts the sweep from word 0.
- RST_ST leaves on the first cycle with RST=0:
  - to INIT if INIT_ZERO=1;
  - to RUN otherwise.
- INIT:
  - Counter k runs 0..TILE_DEPTH-1.
  - Each cycle, every tile writes all-zero, full mask, at word k, in parallel.
  - After k=TILE_DEPTH-1 is written, go to RUN.
  - Duration is exactly TILE_DEPTH cycles.
  - External CEB/WEB/A/D are ignored: no write, no QVALID.
- RUN: READY=1.
  - Access accepted when CEB=0 in the cycle it is presented.
  - Only the tile addressed by A[AW-1:TA] is enabled; all other tiles keep CEB high and clock-gated.
- Write (CEB=0, WEB=0): bytes with BWEB[i]=0 take D; other bytes keep their old value. No QVALID.
- Read (CEB=0, WEB=1): tile select is registered alongside the macro read and steers the output mux.
- Out-of-range tile index (A[AW-1:TA] >= NUM_TILES, possible only when NUM_TILES is not a power of two):
  - writes are dropped;
  - reads return Q=0 with QVALID=1.
- Accesses while READY=0 are silently dropped.
- Q between reads:
  - OUT_REG=1: Q holds its last value.
  - OUT_REG=0: Q reflects the last-read tile output and is only meaningful when QVALID=1.

## Timing
- Read presented at cycle N:
  - OUT_REG=0: Q/QVALID at N+1.
  - OUT_REG=1: Q/QVALID at N+2.
- Throughput: one access per cycle, back-to-back reads and writes in any mix.
- Write at N followed by a read of the same address at N+1 returns the newly written data.
- Reads to different tiles on consecutive cycles return data in issue order, with no bubble.
- READY timing after RST deasserts (RST=0 first sampled at cycle R):
  - rises at R+1+TILE_DEPTH with INIT_ZERO=1;
  - rises at R+1 with INIT_ZERO=0.
- Reset values: READY=0, QVALID=0, Q=0 when OUT_REG=1; Q undefined when OUT_REG=0.

## Structure
- Shared package std_mem_pkg holds:
  - the state enum (RST_ST/INIT/RUN);
  - the clog2 helper;
  - the macro-selection defines (FPGA / SMIC12 / default TSMC).
- Sub-module std_spram_tile: one TILE_DEPTH x DATA_WIDTH single-port tile.
  - Inputs are CLK, CEB, WEB, bit-expanded BWEB, A[TA-1:0], D; output is Q.
  - Contains the per-technology macro choice and ICG enabled by ~CEB.
  - Has an FPGA behavioural model with bit-level write enable.
- The top level contains the FSM, init counter, tile decode, byte-to-bit mask expansion, read pipeline and output mux.

## Test plan
- Reset/init, INIT_ZERO=1, TILE_DEPTH=32, NUM_TILES=4:
  - release RST → READY low for exactly 32 cycles;
  - then reads of addresses 0, 37, 127 → Q=0, QVALID one cycle after each read.
- Byte mask:
  - write 0xAABBCCDD to address 5 with BWEB=0000, then 0x11223344 with BWEB=1010;
  - read address 5 → 0xAA22CC44.
- Back-to-back across tiles:
  - write A=3←0x1, A=35←0x2, A=99←0x3;
  - then reads 3, 35, 99 on consecutive cycles → Q=1, 2, 3 on consecutive cycles (N+1; N+2 with OUT_REG=1).
- Write then read same address:
  - write 0xDEADBEEF to A=64 at cycle N, read A=64 at N+1 → Q=0xDEADBEEF.
- Reset mid-INIT:
  - assert RST at init count 10 → READY stays low;
  - the full 32-cycle sweep restarts after release;
  - a write attempted during INIT is not stored (later read → 0).
- Out-of-range, NUM_TILES=3:
  - write to A with tile index 3 → no tile changes;
  - read of that address → Q=0, QVALID=1.
